// File: rtl/motion_pixel_pkg.sv
// Shared types and constants for the motion-detection pixel core.
// Holds the frame FSM encoding, counter limits and packed input-beat layout.
package motion_pixel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [15:0] FRAME_CNT_MAX = 16'hFFFF;
    localparam logic [7:0]  ABORT_CNT_MAX = 8'hFF;

    // Field index within s_axis_tdata; the bit offset is field * PIX_W.
    localparam int CUR_FIELD = 0;
    localparam int REF_FIELD = 1;

endpackage

// File: rtl/motion_abs_diff.sv
// Combinational absolute pixel difference with a strict threshold compare.
// The subtraction is one bit wider so the sign of cur-ref is never lost.
module motion_abs_diff #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    input  logic [PIX_W-1:0] thresh_i,
    output logic             changed_o
);
    logic [PIX_W:0]   delta;
    logic [PIX_W:0]   delta_neg;
    logic [PIX_W-1:0] diff;

    always_comb begin
        delta     = {1'b0, a_i} - {1'b0, b_i};
        delta_neg = -delta;
        diff      = delta[PIX_W] ? delta_neg[PIX_W-1:0] : delta[PIX_W-1:0];
        changed_o = (diff > thresh_i);
    end

endmodule

// File: rtl/motion_pixel_core.sv
// Streaming motion detector: per-pixel change mask out, per-frame change count
// and motion decision in, feeding the status words of the register slave.
module motion_pixel_core
    import motion_pixel_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int COUNT_W = 24,
    parameter int LINE_W  = 12
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [2*PIX_W-1:0]   s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tlast,
    output logic [PIX_W-1:0]     m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tlast,
    input  logic                 cfg_enable,
    input  logic [PIX_W-1:0]     cfg_pix_thresh,
    input  logic [COUNT_W-1:0]   cfg_count_thresh,
    input  logic [LINE_W-1:0]    cfg_height,
    input  logic                 cfg_irq_clear,
    output logic [COUNT_W-1:0]   stat_count,
    output logic                 stat_motion,
    output logic [15:0]          stat_frame_cnt,
    output logic [7:0]           stat_abort_cnt,
    output logic                 irq
);
    localparam int CUR_LSB = CUR_FIELD * PIX_W;
    localparam int REF_LSB = REF_FIELD * PIX_W;
    localparam logic [COUNT_W-1:0] ACC_MAX = {COUNT_W{1'b1}};

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   acc_q, acc_d;
    logic [LINE_W-1:0]    line_q, line_d;
    logic [COUNT_W-1:0]   stat_count_q, stat_count_d;
    logic                 stat_motion_q, stat_motion_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [7:0]           abort_cnt_q, abort_cnt_d;
    logic                 irq_q, irq_d;
    logic [PIX_W-1:0]     m_tdata_q, m_tdata_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic                 m_tuser_q, m_tuser_d;
    logic                 m_tlast_q, m_tlast_d;

    logic                 changed;
    logic                 in_fire;
    logic                 sof_start;
    logic                 irq_set;
    logic [LINE_W-1:0]    height_eff;
    logic [LINE_W-1:0]    line_inc;
    logic [COUNT_W-1:0]   acc_inc;
    logic [COUNT_W-1:0]   acc_first;

    motion_abs_diff #(.PIX_W(PIX_W)) u_abs_diff (
        .a_i       (s_axis_tdata[CUR_LSB +: PIX_W]),
        .b_i       (s_axis_tdata[REF_LSB +: PIX_W]),
        .thresh_i  (cfg_pix_thresh),
        .changed_o (changed)
    );

    assign s_axis_tready = m_axis_tready | ~m_tvalid_q;
    assign in_fire       = s_axis_tvalid & s_axis_tready;
    assign sof_start     = in_fire & s_axis_tuser & cfg_enable;
    assign height_eff    = (cfg_height == '0) ? LINE_W'(1) : cfg_height;
    assign line_inc      = line_q + LINE_W'(1);
    assign acc_first     = COUNT_W'(changed);
    assign acc_inc       = (acc_q == ACC_MAX) ? acc_q : acc_q + COUNT_W'(changed);

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        line_d        = line_q;
        stat_count_d  = stat_count_q;
        stat_motion_d = stat_motion_q;
        frame_cnt_d   = frame_cnt_q;
        abort_cnt_d   = abort_cnt_q;
        irq_set       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sof_start) begin
                    state_d = ST_ACTIVE;
                    acc_d   = acc_first;
                    line_d  = '0;
                end
            end
            ST_ACTIVE: begin
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    line_d  = '0;
                end else if (in_fire) begin
                    if (s_axis_tuser) begin
                        // Early SOF: the partial frame is dropped and this beat opens a new one.
                        if (abort_cnt_q != ABORT_CNT_MAX)
                            abort_cnt_d = abort_cnt_q + 8'd1;
                        acc_d  = acc_first;
                        line_d = '0;
                    end else begin
                        acc_d = acc_inc;
                        if (s_axis_tlast) begin
                            line_d = line_inc;
                            if (line_inc == height_eff)
                                state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                stat_count_d  = acc_q;
                stat_motion_d = (acc_q > cfg_count_thresh);
                irq_set       = (acc_q > cfg_count_thresh);
                frame_cnt_d   = (frame_cnt_q == FRAME_CNT_MAX) ? '0 : frame_cnt_q + 16'd1;
                state_d       = ST_IDLE;
                acc_d         = '0;
                line_d        = '0;
                if (sof_start) begin
                    state_d = ST_ACTIVE;
                    acc_d   = acc_first;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign irq_d = irq_set | (irq_q & ~cfg_irq_clear);

    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tuser_d  = m_tuser_q;
        m_tlast_d  = m_tlast_q;
        if (s_axis_tready) begin
            m_tvalid_d = s_axis_tvalid;
            if (s_axis_tvalid) begin
                m_tdata_d = (cfg_enable & changed) ? {PIX_W{1'b1}} : '0;
                m_tuser_d = s_axis_tuser;
                m_tlast_d = s_axis_tlast;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            line_q        <= '0;
            stat_count_q  <= '0;
            stat_motion_q <= 1'b0;
            frame_cnt_q   <= '0;
            abort_cnt_q   <= '0;
            irq_q         <= 1'b0;
            m_tdata_q     <= '0;
            m_tvalid_q    <= 1'b0;
            m_tuser_q     <= 1'b0;
            m_tlast_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            line_q        <= line_d;
            stat_count_q  <= stat_count_d;
            stat_motion_q <= stat_motion_d;
            frame_cnt_q   <= frame_cnt_d;
            abort_cnt_q   <= abort_cnt_d;
            irq_q         <= irq_d;
            m_tdata_q     <= m_tdata_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tuser_q     <= m_tuser_d;
            m_tlast_q     <= m_tlast_d;
        end
    end

    assign m_axis_tdata   = m_tdata_q;
    assign m_axis_tvalid  = m_tvalid_q;
    assign m_axis_tuser   = m_tuser_q;
    assign m_axis_tlast   = m_tlast_q;
    assign stat_count     = stat_count_q;
    assign stat_motion    = stat_motion_q;
    assign stat_frame_cnt = frame_cnt_q;
    assign stat_abort_cnt = abort_cnt_q;
    assign irq            = irq_q;

endmodule

// File: doc/motion_pixel_core.md
Name: motion_pixel_core

Overview:
- Streaming motion-detection datapath that sits directly behind the motion_detector AXI-Lite register slave.
- Consumes its control registers (enable, pixel threshold, count threshold, frame height, IRQ clear) and produces the status words that slave exposes for readback (changed-pixel count, motion flag, frame counter, IRQ).
- Pixel input is an AXI4-Stream carrying current and reference (background) grayscale pixels packed per beat.
- Output is a binary motion-mask stream.

Parameters:
- PIX_W, 8, grayscale pixel width in bits.
- COUNT_W, 24, width of the changed-pixel counter and the count threshold.
- LINE_W, 12, width of the line counter and cfg_height.

Ports:
- ACLK  in  1  block clock.
- ARESET  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  2*PIX_W  [PIX_W-1:0] current pixel, [2*PIX_W-1:PIX_W] reference pixel.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted.
- s_axis_tuser  in  1  start of frame (first pixel of frame).
- s_axis_tlast  in  1  end of line.
- m_axis_tdata  out  PIX_W  mask pixel: all ones if changed, else zero.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  forwarded SOF.
- m_axis_tlast  out  1  forwarded EOL.
- cfg_enable  in  1  register 0 bit 0.
- cfg_pix_thresh  in  PIX_W  register 1: per-pixel difference threshold.
- cfg_count_thresh  in  COUNT_W  register 2: motion decision threshold.
- cfg_height  in  LINE_W  register 3: lines per frame; 0 is treated as 1.
- cfg_irq_clear  in  1  single-cycle pulse from register 0 bit 1 write.
- stat_count  out  COUNT_W  changed-pixel count of the last completed frame.
- stat_motion  out  1  last completed frame had stat_count > cfg_count_thresh.
- stat_frame_cnt  out  16  completed frames since reset; wraps at 0xFFFF.
- stat_abort_cnt  out  8  frames aborted by early SOF; saturates at 0xFF.
- irq  out  1  sticky motion interrupt.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, accumulator 0, line counter 0.
- Datapath:
  - diff = |cur - ref| computed at PIX_W+1 bits, result PIX_W.
  - A pixel is changed when diff > cfg_pix_thresh (strict comparison).
- Output stage:
  - One register stage, so latency is 1 cycle from the input handshake to m_axis_tvalid.
  - s_axis_tready = m_axis_tready | ~m_axis_tvalid.
  - m_axis_* is held stable while tvalid=1 and tready=0.
  - The mask stream passes regardless of FSM state; its tdata is 0 when cfg_enable=0.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE -> ACTIVE on an accepted beat with tuser=1 while cfg_enable=1. Accumulator is loaded with that beat's changed bit; line counter is cleared.
  - ACTIVE, each accepted beat: accumulator += changed, saturating at 2^COUNT_W-1.
  - ACTIVE, accepted beat with tlast=1: line counter increments. If the new line count equals max(cfg_height,1), go to DONE.
  - ACTIVE, accepted beat with tuser=1 (early SOF): increment stat_abort_cnt, discard the accumulator, and restart accumulation from this beat. FSM stays in ACTIVE.
  - ACTIVE, cfg_enable falls: return to IDLE, discard the accumulator, no status update.
  - DONE, one cycle, no input gating:
    - Latch stat_count = accumulator.
    - stat_motion = accumulator > cfg_count_thresh.
    - Increment stat_frame_cnt.
    - If stat_motion is being set, irq <= 1.
    - Then go to IDLE. A SOF beat accepted during DONE is handled as the IDLE->ACTIVE transition in the same cycle.
- irq:
  - Sticky; cleared by cfg_irq_clear.
  - If the set and the clear coincide, set wins.
- Config values are sampled live; changing thresholds mid-frame affects subsequent pixels only.
- ARESET asserted mid-frame: immediate return to reset state; the partial frame is lost and no counts are updated.

Decomposition:
- Package motion_pixel_pkg holds:
  - the FSM state enum (IDLE, ACTIVE, DONE);
  - localparams for the counter maxima;
  - the packed input-beat field offsets.
- One sub-module, motion_abs_diff: combinational |a-b| plus threshold compare.
- The FSM, counters and output register stay in the top module.

Test Plan:
- 4x2 frame, cfg_height=2, cfg_pix_thresh=10, cfg_count_thresh=3, 5 pixels with diff 11 and 3 with diff 10 -> stat_count=5, stat_motion=1, irq=1, stat_frame_cnt=1, mask=0xFF exactly on the diff-11 beats.
- Same frame with cfg_count_thresh=5 -> stat_count=5, stat_motion=0, irq stays 0.
- Hold m_axis_tready low for 3 cycles mid-line -> s_axis_tready low, m_axis data held stable, no beat lost or duplicated, final count unchanged.
- SOF after 1 line of a 2-line frame -> stat_abort_cnt=1, the following full frame reports only its own count.
- irq set then cfg_irq_clear pulse -> irq=0. Clear coinciding with a new motion frame -> irq=1.
- ARESET asserted mid-frame, then a full frame -> all stats 0 after reset, then stat_frame_cnt=1 after the new frame.
